// File: rtl/phs_axil_pkg.sv
// Shared types and constants for the phs_axil_regfile AXI4-Lite register block:
// word-slot map, AXI response encodings and the write/read FSM state enums.
package phs_axil_pkg;

    typedef logic [2:0] slot_t;

    localparam int unsigned NumCtrl     = 4;
    localparam slot_t       SlotStatus  = 3'd4;
    localparam slot_t       SlotWrCount = 3'd5;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_NEED_W, W_NEED_AW, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    // Slots 0..3 are the writable control registers.
    function automatic logic is_ctrl_slot(slot_t slot);
        return slot < SlotStatus;
    endfunction

endpackage

// File: rtl/phs_axil_regfile_if.sv
// AXI4-Lite bus bundle for phs_axil_regfile (AW, W, B, AR and R channels).
interface phs_axil_regfile_if #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
               S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
               S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
               S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
               S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

endinterface

// File: rtl/phs_axil_strobe_merge.sv
// Per-byte merge: lanes whose strobe bit is set take the new word, others keep the old.
module phs_axil_strobe_merge #(
    parameter int unsigned DataWidth = 32
) (
    input  logic [DataWidth-1:0]   old_word,
    input  logic [DataWidth-1:0]   new_word,
    input  logic [DataWidth/8-1:0] strb,
    output logic [DataWidth-1:0]   merged_word
);

    // Lane-by-lane select between old and new bytes.
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < DataWidth / 8; i++) begin
            if (strb[i]) begin
                merged_word[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/phs_axil_regfile.sv
// AXI4-Lite register file: four RW control words, a RO status word and a RO
// write counter. Independent write and read FSMs, one transaction outstanding each.
// Optional macro PHS_AXIL_REGFILE_WSTRB_EN: honour WSTRB byte lanes on control writes;
// when undefined every OKAY write replaces the full word.
module phs_axil_regfile
    import phs_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                                      S_AXI_ACLK,
    input  logic                                      S_AXI_ARESETN,
    phs_axil_regfile_if.slave                         s_axi,
    output logic [NumCtrl-1:0][C_S_AXI_DATA_WIDTH-1:0] phs_ctrl_o,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             phs_status_i
);

    localparam int unsigned StrbWidth = C_S_AXI_DATA_WIDTH / 8;

    w_state_e                                  w_state;
    slot_t                                     aw_slot_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]             w_data_q;
    logic [StrbWidth-1:0]                      w_strb_q;
    logic                                      awready_q, wready_q, bvalid_q;
    logic [1:0]                                bresp_q;

    r_state_e                                  r_state;
    logic                                      arready_q, rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]             rdata_q;
    logic [1:0]                                rresp_q;

    logic [NumCtrl-1:0][C_S_AXI_DATA_WIDTH-1:0] ctrl_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]             wr_count_q;

    slot_t                                     aw_slot, ar_slot, commit_slot;
    logic                                      aw_hs, w_hs, ar_hs, commit_en, commit_ok;
    logic [C_S_AXI_DATA_WIDTH-1:0]             commit_data, merged, rd_data;
    logic [StrbWidth-1:0]                      commit_strb, eff_strb;
    logic [1:0]                                rd_resp;

    assign aw_slot = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_slot = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign aw_hs   = s_axi.S_AXI_AWVALID && awready_q;
    assign w_hs    = s_axi.S_AXI_WVALID && wready_q;
    assign ar_hs   = s_axi.S_AXI_ARVALID && arready_q;

    // Commit happens on the edge that completes the later of the AW/W handshakes.
    always_comb begin
        commit_en   = 1'b0;
        commit_slot = aw_slot_q;
        commit_data = w_data_q;
        commit_strb = w_strb_q;
        unique case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit_en   = 1'b1;
                    commit_slot = aw_slot;
                    commit_data = s_axi.S_AXI_WDATA;
                    commit_strb = s_axi.S_AXI_WSTRB;
                end
            end
            W_NEED_W: begin
                if (w_hs) begin
                    commit_en   = 1'b1;
                    commit_data = s_axi.S_AXI_WDATA;
                    commit_strb = s_axi.S_AXI_WSTRB;
                end
            end
            W_NEED_AW: begin
                if (aw_hs) begin
                    commit_en   = 1'b1;
                    commit_slot = aw_slot;
                end
            end
            W_RESP: ;
        endcase
    end

    assign commit_ok = commit_en && is_ctrl_slot(commit_slot);

`ifdef PHS_AXIL_REGFILE_WSTRB_EN
    assign eff_strb = commit_strb;
`else
    logic unused_strb;
    assign eff_strb    = '1;
    assign unused_strb = ^commit_strb;
`endif

    phs_axil_strobe_merge #(
        .DataWidth (C_S_AXI_DATA_WIDTH)
    ) u_merge (
        .old_word    (ctrl_q[commit_slot[1:0]]),
        .new_word    (commit_data),
        .strb        (eff_strb),
        .merged_word (merged)
    );

    // Write FSM with registered ready/response outputs.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            w_state   <= W_IDLE;
            aw_slot_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
        end else if (commit_en) begin
            w_state   <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= commit_ok ? RespOkay : RespSlverr;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    if (aw_hs) begin
                        aw_slot_q <= aw_slot;
                        awready_q <= 1'b0;
                        w_state   <= W_NEED_W;
                    end else if (w_hs) begin
                        w_data_q <= s_axi.S_AXI_WDATA;
                        w_strb_q <= s_axi.S_AXI_WSTRB;
                        wready_q <= 1'b0;
                        w_state  <= W_NEED_AW;
                    end
                end
                W_NEED_W, W_NEED_AW: ;
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Control registers and write counter; SLVERR writes leave both untouched.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            ctrl_q     <= '0;
            wr_count_q <= '0;
        end else if (commit_ok) begin
            ctrl_q[commit_slot[1:0]] <= merged;
            wr_count_q               <= wr_count_q + C_S_AXI_DATA_WIDTH'(1);
        end
    end

    // Read data mux; sees pre-commit register values.
    always_comb begin
        rd_data = '0;
        rd_resp = RespOkay;
        if (is_ctrl_slot(ar_slot)) begin
            rd_data = ctrl_q[ar_slot[1:0]];
        end else if (ar_slot == SlotStatus) begin
            rd_data = phs_status_i;
        end else if (ar_slot == SlotWrCount) begin
            rd_data = wr_count_q;
        end else begin
            rd_resp = RespSlverr;
        end
    end

    // Read FSM: accept in R_IDLE, hold registered data in R_DATA until RREADY.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        rdata_q   <= rd_data;
                        rresp_q   <= rd_resp;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi.S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign phs_ctrl_o          = ctrl_q;

    // Protection bits and byte offsets carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_phs_axil_regfile.sv
// Directed bench for phs_axil_regfile: vector table plus hand-written multi-cycle sequences.
module tb_phs_axil_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0][31:0] ctrl;
    logic [31:0] status = 32'hCAFE_F00D;

    int n_tests = 0;
    int n_fail  = 0;

    phs_axil_regfile_if intf ();

    phs_axil_regfile dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (intf),
        .phs_ctrl_o    (ctrl),
        .phs_status_i  (status)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        is_write;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    function automatic vec_t mkv(logic w, logic [4:0] a, logic [31:0] d, logic [3:0] s,
                                 logic [1:0] r, logic [31:0] rd);
        vec_t v;
        v.is_write = w; v.addr = a; v.data = d; v.strb = s; v.resp = r; v.rdata = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout required handshake", name);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done, hs_aw, hs_w;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        @(negedge clk);
        intf.S_AXI_AWADDR = addr; intf.S_AXI_AWVALID = 1'b1;
        intf.S_AXI_WDATA = data; intf.S_AXI_WSTRB = strb; intf.S_AXI_WVALID = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            hs_aw = intf.S_AXI_AWVALID && intf.S_AXI_AWREADY;
            hs_w  = intf.S_AXI_WVALID && intf.S_AXI_WREADY;
            @(negedge clk);
            n++;
            if (hs_aw) begin intf.S_AXI_AWVALID = 1'b0; aw_done = 1; end
            if (hs_w)  begin intf.S_AXI_WVALID = 1'b0;  w_done = 1;  end
        end
        if (!(aw_done && w_done)) begin
            timeout("write_accept");
            intf.S_AXI_AWVALID = 1'b0; intf.S_AXI_WVALID = 1'b0;
            resp = 2'bxx;
            return;
        end
        intf.S_AXI_BREADY = 1'b1;
        n = 0;
        while (!intf.S_AXI_BVALID && n < 20) begin @(negedge clk); n++; end
        if (!intf.S_AXI_BVALID) begin
            timeout("write_bvalid");
            intf.S_AXI_BREADY = 1'b0;
            resp = 2'bxx;
            return;
        end
        resp = intf.S_AXI_BRESP;
        @(negedge clk);
        intf.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        n = 0;
        @(negedge clk);
        intf.S_AXI_ARADDR = addr; intf.S_AXI_ARVALID = 1'b1;
        while (!intf.S_AXI_ARREADY && n < 20) begin @(negedge clk); n++; end
        if (!intf.S_AXI_ARREADY) begin
            timeout("read_accept");
            intf.S_AXI_ARVALID = 1'b0;
            data = 'x; resp = 2'bxx;
            return;
        end
        @(negedge clk);
        intf.S_AXI_ARVALID = 1'b0;
        intf.S_AXI_RREADY = 1'b1;
        n = 0;
        while (!intf.S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
        if (!intf.S_AXI_RVALID) begin
            timeout("read_rvalid");
            intf.S_AXI_RREADY = 1'b0;
            data = 'x; resp = 2'bxx;
            return;
        end
        data = intf.S_AXI_RDATA;
        resp = intf.S_AXI_RRESP;
        @(negedge clk);
        intf.S_AXI_RREADY = 1'b0;
    endtask

    vec_t        vecs[19];
    logic [31:0] rd;
    logic [1:0]  rs;
    logic [31:0] exp_strb_word;

    initial begin
        intf.S_AXI_AWADDR = '0; intf.S_AXI_AWPROT = '0; intf.S_AXI_AWVALID = 1'b0;
        intf.S_AXI_WDATA = '0;  intf.S_AXI_WSTRB = '0;  intf.S_AXI_WVALID = 1'b0;
        intf.S_AXI_BREADY = 1'b0;
        intf.S_AXI_ARADDR = '0; intf.S_AXI_ARPROT = '0; intf.S_AXI_ARVALID = 1'b0;
        intf.S_AXI_RREADY = 1'b0;

`ifdef PHS_AXIL_REGFILE_WSTRB_EN
        exp_strb_word = 32'hAA22_CC44;
`else
        exp_strb_word = 32'h1122_3344;
`endif
        vecs[0]  = mkv(1, 5'h00, 32'h1, 4'hF, 2'b00, 32'h0);
        vecs[1]  = mkv(1, 5'h04, 32'h2, 4'hF, 2'b00, 32'h0);
        vecs[2]  = mkv(1, 5'h08, 32'h3, 4'hF, 2'b00, 32'h0);
        vecs[3]  = mkv(1, 5'h0C, 32'h4, 4'hF, 2'b00, 32'h0);
        vecs[4]  = mkv(0, 5'h00, 32'h0, 4'h0, 2'b00, 32'h1);
        vecs[5]  = mkv(0, 5'h04, 32'h0, 4'h0, 2'b00, 32'h2);
        vecs[6]  = mkv(0, 5'h08, 32'h0, 4'h0, 2'b00, 32'h3);
        vecs[7]  = mkv(0, 5'h0C, 32'h0, 4'h0, 2'b00, 32'h4);
        vecs[8]  = mkv(0, 5'h14, 32'h0, 4'h0, 2'b00, 32'h4);
        vecs[9]  = mkv(0, 5'h10, 32'h0, 4'h0, 2'b00, 32'hCAFE_F00D);
        vecs[10] = mkv(1, 5'h18, 32'hDEAD, 4'hF, 2'b10, 32'h0);
        vecs[11] = mkv(0, 5'h1C, 32'h0, 4'h0, 2'b10, 32'h0);
        vecs[12] = mkv(0, 5'h14, 32'h0, 4'h0, 2'b00, 32'h4);
        vecs[13] = mkv(1, 5'h10, 32'hBEEF, 4'hF, 2'b10, 32'h0);
        vecs[14] = mkv(1, 5'h06, 32'hAABB_CCDD, 4'hF, 2'b00, 32'h0);
        vecs[15] = mkv(1, 5'h04, 32'h1122_3344, 4'h5, 2'b00, 32'h0);
        vecs[16] = mkv(0, 5'h04, 32'h0, 4'h0, 2'b00, exp_strb_word);
        vecs[17] = mkv(0, 5'h14, 32'h0, 4'h0, 2'b00, 32'h6);
        vecs[18] = mkv(0, 5'h18, 32'h0, 4'h0, 2'b10, 32'h0);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 32'(intf.S_AXI_AWREADY), 32'h0);
        check("rst_wready",  32'(intf.S_AXI_WREADY),  32'h0);
        check("rst_arready", 32'(intf.S_AXI_ARREADY), 32'h0);
        check("rst_bvalid",  32'(intf.S_AXI_BVALID),  32'h0);
        check("rst_rvalid",  32'(intf.S_AXI_RVALID),  32'h0);
        check("rst_bresp",   32'(intf.S_AXI_BRESP),   32'h0);
        check("rst_rresp",   32'(intf.S_AXI_RRESP),   32'h0);
        check("rst_rdata",   intf.S_AXI_RDATA,        32'h0);
        check("rst_ctrl",    32'(|ctrl),              32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_arready", 32'(intf.S_AXI_ARREADY), 32'h1);

        // Table of single transactions.
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].is_write) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
                check($sformatf("vec%0d_bresp", i), 32'(rs), 32'(vecs[i].resp));
            end else begin
                axi_read(vecs[i].addr, rd, rs);
                check($sformatf("vec%0d_rresp", i), 32'(rs), 32'(vecs[i].resp));
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            end
        end
        check("ctrl0", ctrl[0], 32'h1);
        check("ctrl1", ctrl[1], exp_strb_word);
        check("ctrl2", ctrl[2], 32'h3);
        check("ctrl3", ctrl[3], 32'h4);

        // Read and write to slot 0 accepted on the same edge: read sees the old value.
        @(negedge clk);
        intf.S_AXI_AWADDR = 5'h00; intf.S_AXI_AWVALID = 1'b1;
        intf.S_AXI_WDATA = 32'h99; intf.S_AXI_WSTRB = 4'hF; intf.S_AXI_WVALID = 1'b1;
        intf.S_AXI_ARADDR = 5'h00; intf.S_AXI_ARVALID = 1'b1;
        check("same_awready", 32'(intf.S_AXI_AWREADY), 32'h1);
        check("same_wready",  32'(intf.S_AXI_WREADY),  32'h1);
        check("same_arready", 32'(intf.S_AXI_ARREADY), 32'h1);
        @(negedge clk);
        intf.S_AXI_AWVALID = 1'b0; intf.S_AXI_WVALID = 1'b0; intf.S_AXI_ARVALID = 1'b0;
        check("same_rvalid", 32'(intf.S_AXI_RVALID), 32'h1);
        check("same_rdata",  intf.S_AXI_RDATA,       32'h1);
        check("same_bvalid", 32'(intf.S_AXI_BVALID), 32'h1);
        check("same_ctrl0",  ctrl[0],                32'h99);
        intf.S_AXI_BREADY = 1'b1; intf.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        intf.S_AXI_BREADY = 1'b0; intf.S_AXI_RREADY = 1'b0;
        axi_read(5'h00, rd, rs);
        check("same_readback", rd, 32'h99);

        // W three cycles ahead of AW, then BREADY held low while a new AW/W waits.
        @(negedge clk);
        intf.S_AXI_WDATA = 32'h55; intf.S_AXI_WSTRB = 4'hF; intf.S_AXI_WVALID = 1'b1;
        check("wfirst_wready", 32'(intf.S_AXI_WREADY), 32'h1);
        @(negedge clk);
        intf.S_AXI_WVALID = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("wfirst_wait%0d_wready", k), 32'(intf.S_AXI_WREADY), 32'h0);
            check($sformatf("wfirst_wait%0d_bvalid", k), 32'(intf.S_AXI_BVALID), 32'h0);
            @(negedge clk);
        end
        intf.S_AXI_AWADDR = 5'h0C; intf.S_AXI_AWVALID = 1'b1;
        check("wfirst_awready", 32'(intf.S_AXI_AWREADY), 32'h1);
        @(negedge clk);
        intf.S_AXI_WDATA = 32'h77; intf.S_AXI_WVALID = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bhold%0d_bvalid", k),  32'(intf.S_AXI_BVALID),  32'h1);
            check($sformatf("bhold%0d_bresp", k),   32'(intf.S_AXI_BRESP),   32'h0);
            check($sformatf("bhold%0d_awready", k), 32'(intf.S_AXI_AWREADY), 32'h0);
            check($sformatf("bhold%0d_wready", k),  32'(intf.S_AXI_WREADY),  32'h0);
            check($sformatf("bhold%0d_ctrl3", k),   ctrl[3],                 32'h55);
            @(negedge clk);
        end
        intf.S_AXI_AWVALID = 1'b0; intf.S_AXI_WVALID = 1'b0; intf.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        intf.S_AXI_BREADY = 1'b0;
        check("bhold_done_bvalid", 32'(intf.S_AXI_BVALID), 32'h0);
        axi_read(5'h0C, rd, rs);
        check("wfirst_readback", rd, 32'h55);
        axi_read(5'h14, rd, rs);
        check("wfirst_count", rd, 32'h8);

        // Reset while waiting for W after AW to slot 2.
        @(negedge clk);
        intf.S_AXI_AWADDR = 5'h08; intf.S_AXI_AWVALID = 1'b1;
        check("rstmid_awready", 32'(intf.S_AXI_AWREADY), 32'h1);
        @(negedge clk);
        intf.S_AXI_AWVALID = 1'b0;
        check("rstmid_need_w_wready", 32'(intf.S_AXI_WREADY), 32'h1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rstmid_bvalid", 32'(intf.S_AXI_BVALID), 32'h0);
        check("rstmid_arready_low", 32'(intf.S_AXI_ARREADY), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_arready_after", 32'(intf.S_AXI_ARREADY), 32'h1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rstmid_post%0d_bvalid", k), 32'(intf.S_AXI_BVALID), 32'h0);
            @(negedge clk);
        end
        axi_read(5'h08, rd, rs);
        check("rstmid_reg2", rd, 32'h0);
        axi_read(5'h14, rd, rs);
        check("rstmid_count", rd, 32'h0);
        check("rstmid_ctrl", 32'(|ctrl), 32'h0);
        axi_write(5'h08, 32'h5A, 4'hF, rs);
        check("post_rst_bresp", 32'(rs), 32'h0);
        axi_read(5'h08, rd, rs);
        check("post_rst_reg2", rd, 32'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phs_axil_regfile.md
PHS_AXIL_REGFILE -- requirements
Module: phs_axil_regfile

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width covering 8 word slots.
REQ-003 SHALL have port S_AXI_ACLK, in, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port S_AXI_ARESETN, in, 1, reset, synchronous and active-low.
REQ-005 SHALL have AW channel ports S_AXI_AWADDR in 5, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1 and S_AXI_AWREADY out 1.
REQ-006 SHALL have W channel ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1 and S_AXI_WREADY out 1.
REQ-007 SHALL have B channel ports S_AXI_BRESP out 2, S_AXI_BVALID out 1 and S_AXI_BREADY in 1.
REQ-008 SHALL have AR channel ports S_AXI_ARADDR in 5, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1 and S_AXI_ARREADY out 1.
REQ-009 SHALL have R channel ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1 and S_AXI_RREADY in 1.
REQ-010 SHALL have port phs_ctrl_o, out, 4x32 packed, current contents of RW registers 0..3.
REQ-011 SHALL have port phs_status_i, in, 32, status word sampled on reads of slot 4.

Function
REQ-012 SHALL use the address map: word slots 0-3 (0x00-0x0C) RW; slot 4 (0x10) RO phs_status_i; slot 5 (0x14) RO write counter; slots 6-7 unmapped.
REQ-013 SHALL decode AWADDR[4:2] and ARADDR[4:2] and ignore bits [1:0].
REQ-014 SHALL implement the write FSM with states W_IDLE, W_NEED_W, W_NEED_AW and W_RESP.
REQ-015 SHALL capture AW and W in W_IDLE when both are valid in the same cycle, go to W_RESP, and assert AWREADY/WREADY for exactly that one cycle.
REQ-016 SHALL, in W_IDLE with only AWVALID, capture the address and go to W_NEED_W; with only WVALID, capture data/strobe and go to W_NEED_AW.
REQ-017 SHALL commit the register update on the cycle entering W_RESP, assert BVALID in W_RESP, and hold BVALID, BRESP stable until BREADY is high, then return to W_IDLE.
REQ-018 SHALL return BRESP=OKAY (00) for slots 0-3 and SLVERR (10) for slots 4-7, with no state change on SLVERR.
REQ-019 SHALL give the write counter (slot 5) 32 bits, increment it on every OKAY commit, wrap 0xFFFFFFFF to 0, and not count SLVERR.
REQ-020 SHALL implement the read FSM with states R_IDLE and R_DATA; ARREADY is high in R_IDLE, the address is accepted on ARVALID&&ARREADY, RDATA is registered, and RVALID is asserted the next cycle.
REQ-021 SHALL hold RVALID, RDATA and RRESP stable in R_DATA until RREADY, then return to R_IDLE with ARREADY low during R_DATA.
REQ-022 SHALL return RRESP=OKAY for slots 0-5 and SLVERR with RDATA=0 for slots 6-7.
REQ-023 SHALL run the read and write FSMs independently; a read accepted in the same cycle as a write commit to the same slot returns the pre-commit value.
REQ-024 SHALL allow at most one outstanding write and one outstanding read, with no AW/W acceptance while in W_RESP.

Reset
REQ-025 SHALL, while S_AXI_ARESETN=0 at a clock edge, set FSMs to W_IDLE/R_IDLE, registers 0-3 to 0, the write counter to 0, and AWREADY, WREADY, ARREADY, BVALID and RVALID to 0, with BRESP, RRESP and RDATA at 0.
REQ-026 SHALL, on reset mid-transaction, discard the pending transaction with no register update and no response issued.
REQ-027 SHALL raise ARREADY on the first cycle after reset release.

Configuration
REQ-028 SHALL honour WSTRB per byte lane for slots 0-3 when PHS_AXIL_REGFILE_WSTRB_EN is defined, so that only lanes with strobe=1 update.
REQ-029 SHALL, without PHS_AXIL_REGFILE_WSTRB_EN, ignore WSTRB and write the full 32-bit word on every OKAY write.

Structure
REQ-030 SHALL place address slot constants, RESP encodings (OKAY, SLVERR) and the write/read FSM state enums in package phs_axil_pkg.
REQ-031 SHALL implement the per-byte strobe merge as a sub-module phs_axil_strobe_merge (old word, new word, strobe -> merged word).

Verification
REQ-032 SHALL cover: write 0x1,0x2,0x3,0x4 to 0x00..0x0C -> four BRESP=OKAY; reads return 0x1..0x4; slot 5 reads 4.
REQ-033 SHALL cover: W presented 3 cycles before AW, with BREADY held low for 5 cycles -> single commit, BVALID stable throughout, no second AW/W accepted.
REQ-034 SHALL cover: with macro defined, write 0xAABBCCDD to 0x04 then 0x11223344 with WSTRB=0101 -> read 0xAA22CC44; without the macro -> read 0x11223344.
REQ-035 SHALL cover: write to 0x18 and read of 0x1C -> BRESP=SLVERR and RRESP=SLVERR with RDATA=0; write counter unchanged.
REQ-036 SHALL cover: reset asserted in W_NEED_W after AW to 0x08 -> no BVALID, register 2 reads 0, ARREADY high the cycle after release.
